// File: rtl/vga_pattern_gen.sv
// VGA timing and test-pattern generator (solid, bars, grid, gradient) in the pixel clock domain.
// Optional horizontal scrolling of bars/gradient is enabled with `define VGA_PATTERN_SCROLL_EN.
module vga_pattern_gen #(
    parameter int C_resolution_x      = 640,
    parameter int C_hsync_front_porch = 16,
    parameter int C_hsync_pulse       = 96,
    parameter int C_hsync_back_porch  = 48,
    parameter int C_resolution_y      = 480,
    parameter int C_vsync_front_porch = 10,
    parameter int C_vsync_pulse       = 2,
    parameter int C_vsync_back_porch  = 33,
    parameter int C_hsync_polarity    = 0,
    parameter int C_vsync_polarity    = 0,
    parameter int C_depth             = 3
) (
    input  logic                   clk_pixel,
    input  logic                   reset,
    input  logic [1:0]             mode,
    input  logic [3*C_depth-1:0]   color,
    output logic [C_depth-1:0]     red,
    output logic [C_depth-1:0]     green,
    output logic [C_depth-1:0]     blue,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   blank,
    output logic                   frame,
    output logic [10:0]            x,
    output logic [10:0]            y
);

    localparam int H_TOTAL = C_resolution_x + C_hsync_front_porch + C_hsync_pulse + C_hsync_back_porch;
    localparam int V_TOTAL = C_resolution_y + C_vsync_front_porch + C_vsync_pulse + C_vsync_back_porch;

    localparam logic [10:0] RES_X    = 11'(C_resolution_x);
    localparam logic [10:0] RES_Y    = 11'(C_resolution_y);
    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] HS_START = 11'(C_resolution_x + C_hsync_front_porch);
    localparam logic [10:0] HS_END   = 11'(C_resolution_x + C_hsync_front_porch + C_hsync_pulse);
    localparam logic [10:0] VS_START = 11'(C_resolution_y + C_vsync_front_porch);
    localparam logic [10:0] VS_END   = 11'(C_resolution_y + C_vsync_front_porch + C_vsync_pulse);
    localparam logic [10:0] BAR_LAST = 11'(C_resolution_x / 8 - 1);
    localparam logic        HS_ACT   = (C_hsync_polarity != 0);
    localparam logic        VS_ACT   = (C_vsync_polarity != 0);

    logic [10:0]            r_hc;
    logic [10:0]            r_vc;
    logic [7:0]             r_fc;
    logic [1:0]             r_mode;
    logic [3*C_depth-1:0]   r_color;
    logic [2:0]             r_bar_idx;
    logic [10:0]            r_bar_cnt;

    logic                   w_line_end;
    logic                   w_frame_end;
    logic                   w_frame_start;
    logic                   w_visible;
    logic                   w_grid;
    logic                   w_hs_on;
    logic                   w_vs_on;
    logic [1:0]             w_mode;
    logic [3*C_depth-1:0]   w_color;
    logic [10:0]            w_xs;
    logic [13:0]            w_bar_line_init;
    logic [13:0]            w_bar_frame_init;
    logic [C_depth-1:0]     w_r;
    logic [C_depth-1:0]     w_g;
    logic [C_depth-1:0]     w_b;
    logic                   w_unused;

    // Advance a {bar index, position within bar} pair by one pixel.
    function automatic logic [13:0] bar_step(input logic [2:0] idx, input logic [10:0] cnt);
        if (cnt == BAR_LAST)
            return {idx + 3'd1, 11'd0};
        else
            return {idx, cnt + 11'd1};
    endfunction

    assign w_line_end    = (r_hc == H_LAST);
    assign w_frame_end   = w_line_end && (r_vc == V_LAST);
    assign w_frame_start = (r_hc == 11'd0) && (r_vc == 11'd0);
    assign w_visible     = (r_hc < RES_X) && (r_vc < RES_Y);
    assign w_hs_on       = (r_hc >= HS_START) && (r_hc < HS_END);
    assign w_vs_on       = (r_vc >= VS_START) && (r_vc < VS_END);

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            r_hc <= '0;
            r_vc <= '0;
            r_fc <= '0;
        end else if (w_line_end) begin
            r_hc <= '0;
            if (w_frame_end) begin
                r_vc <= '0;
                r_fc <= r_fc + 8'd1;
            end else begin
                r_vc <= r_vc + 11'd1;
            end
        end else begin
            r_hc <= r_hc + 11'd1;
        end
    end

    // The pixel at (0,0) already uses the freshly latched settings, so a frame never mixes two modes.
    assign w_mode  = w_frame_start ? mode  : r_mode;
    assign w_color = w_frame_start ? color : r_color;

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            r_mode  <= '0;
            r_color <= '0;
        end else if (w_frame_start) begin
            r_mode  <= mode;
            r_color <= color;
        end
    end

`ifdef VGA_PATTERN_SCROLL_EN
    logic [10:0] r_so;
    logic [2:0]  r_sb_idx;
    logic [10:0] r_sb_cnt;
    logic [13:0] w_sb_step;
    logic [11:0] w_xs_sum;

    // r_sb tracks the bar position of the scroll offset, so each line can start mid-bar without a divider.
    assign w_sb_step = bar_step(r_sb_idx, r_sb_cnt);

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            r_so     <= '0;
            r_sb_idx <= '0;
            r_sb_cnt <= '0;
        end else if (w_frame_end) begin
            r_so                 <= (r_so == RES_X - 11'd1) ? 11'd0 : r_so + 11'd1;
            {r_sb_idx, r_sb_cnt} <= w_sb_step;
        end
    end

    assign w_bar_line_init  = {r_sb_idx, r_sb_cnt};
    assign w_bar_frame_init = w_sb_step;
    assign w_xs_sum         = {1'b0, r_hc} + {1'b0, r_so};
    assign w_xs             = (w_xs_sum >= {1'b0, RES_X}) ? 11'(w_xs_sum - {1'b0, RES_X}) : w_xs_sum[10:0];
`else
    assign w_bar_line_init  = '0;
    assign w_bar_frame_init = '0;
    assign w_xs             = r_hc;
`endif

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            r_bar_idx <= '0;
            r_bar_cnt <= '0;
        end else if (w_frame_end) begin
            {r_bar_idx, r_bar_cnt} <= w_bar_frame_init;
        end else if (w_line_end) begin
            {r_bar_idx, r_bar_cnt} <= w_bar_line_init;
        end else begin
            {r_bar_idx, r_bar_cnt} <= bar_step(r_bar_idx, r_bar_cnt);
        end
    end

    assign w_grid = (r_hc[4:0] == 5'd0) || (r_vc[4:0] == 5'd0) ||
                    (r_hc == RES_X - 11'd1) || (r_vc == RES_Y - 11'd1);

    // Bar order white..black maps to r = ~idx[1], g = ~idx[2], b = ~idx[0].
    always_comb begin
        w_r = '0;
        w_g = '0;
        w_b = '0;
        if (w_visible) begin
            case (w_mode)
                2'd0: {w_r, w_g, w_b} = w_color;
                2'd1: begin
                    w_r = {C_depth{~r_bar_idx[1]}};
                    w_g = {C_depth{~r_bar_idx[2]}};
                    w_b = {C_depth{~r_bar_idx[0]}};
                end
                2'd2: begin
                    if (w_grid) begin
                        w_r = '1;
                        w_g = '1;
                        w_b = '1;
                    end
                end
                default: begin
                    w_r = w_xs[C_depth+3:4];
                    w_g = r_vc[C_depth+3:4];
                    w_b = r_fc[C_depth-1:0];
                end
            endcase
        end
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            red   <= '0;
            green <= '0;
            blue  <= '0;
            hsync <= ~HS_ACT;
            vsync <= ~VS_ACT;
            blank <= 1'b1;
            frame <= 1'b0;
            x     <= '0;
            y     <= '0;
        end else begin
            red   <= w_r;
            green <= w_g;
            blue  <= w_b;
            hsync <= w_hs_on ? HS_ACT : ~HS_ACT;
            vsync <= w_vs_on ? VS_ACT : ~VS_ACT;
            blank <= ~w_visible;
            frame <= w_frame_start;
            x     <= r_hc;
            y     <= r_vc;
        end
    end

    assign w_unused = ^{r_fc, w_xs};

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Scoreboard bench for vga_pattern_gen: a cycle-count based reference model pushes expected pixels,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_vga_pattern_gen;

    localparam int RX  = 64;
    localparam int HFP = 4;
    localparam int HP  = 8;
    localparam int HBP = 4;
    localparam int RY  = 40;
    localparam int VFP = 2;
    localparam int VP  = 2;
    localparam int VBP = 3;
    localparam int D   = 3;
    localparam int H   = RX + HFP + HP + HBP;
    localparam int V   = RY + VFP + VP + VBP;
    localparam int FR  = H * V;

    typedef logic [34:0] pix_t;
    localparam pix_t RST_PIX = {9'd0, 1'b1, 1'b1, 1'b1, 1'b0, 22'd0};

    logic           clk_pixel = 1'b0;
    logic           reset     = 1'b1;
    logic [1:0]     mode      = 2'd0;
    logic [3*D-1:0] color     = '0;
    logic [D-1:0]   red, green, blue;
    logic           hsync, vsync, blank, frame;
    logic [10:0]    x, y;

    pix_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   t = 0;
    logic [1:0] sh_mode = 2'd0;
    logic [8:0] sh_color = 9'd0;
    int   bar_code[8] = '{7, 6, 3, 2, 5, 4, 1, 0};

    always #5 clk_pixel = ~clk_pixel;

    vga_pattern_gen #(
        .C_resolution_x(RX), .C_hsync_front_porch(HFP), .C_hsync_pulse(HP), .C_hsync_back_porch(HBP),
        .C_resolution_y(RY), .C_vsync_front_porch(VFP), .C_vsync_pulse(VP), .C_vsync_back_porch(VBP),
        .C_hsync_polarity(0), .C_vsync_polarity(0), .C_depth(D)
    ) dut (
        .clk_pixel(clk_pixel), .reset(reset), .mode(mode), .color(color),
        .red(red), .green(green), .blue(blue),
        .hsync(hsync), .vsync(vsync), .blank(blank), .frame(frame),
        .x(x), .y(y)
    );

    // Expected pixel for cycle tt since reset release, derived from raster position arithmetic.
    function automatic pix_t expect_pixel(input int tt, input logic [1:0] md, input logic [8:0] col);
        int h, v, f, so, xs, code;
        logic [2:0] r, g, b;
        logic vis, hs, vs;
        h  = tt % H;
        v  = (tt / H) % V;
        f  = tt / FR;
        so = 0;
`ifdef VGA_PATTERN_SCROLL_EN
        so = f % RX;
`endif
        xs  = (h + so) % RX;
        vis = (h < RX) && (v < RY);
        r = 3'd0; g = 3'd0; b = 3'd0;
        if (vis) begin
            case (md)
                2'd0: begin r = col[8:6]; g = col[5:3]; b = col[2:0]; end
                2'd1: begin
                    code = bar_code[xs / (RX / 8)];
                    r = ((code & 4) != 0) ? 3'd7 : 3'd0;
                    g = ((code & 2) != 0) ? 3'd7 : 3'd0;
                    b = ((code & 1) != 0) ? 3'd7 : 3'd0;
                end
                2'd2: begin
                    if ((h % 32 == 0) || (v % 32 == 0) || (h == RX - 1) || (v == RY - 1)) begin
                        r = 3'd7; g = 3'd7; b = 3'd7;
                    end
                end
                default: begin
                    r = 3'((xs / 16) % 8);
                    g = 3'((v / 16) % 8);
                    b = 3'(f % 8);
                end
            endcase
        end
        hs = !((h >= RX + HFP) && (h < RX + HFP + HP));
        vs = !((v >= RY + VFP) && (v < RY + VFP + VP));
        return {r, g, b, hs, vs, !vis, (h == 0 && v == 0), 11'(h), 11'(v)};
    endfunction

    // Reference model: one expected entry per clock edge.
    initial begin
        forever begin
            @(posedge clk_pixel);
            if (reset) begin
                t        = 0;
                sh_mode  = 2'd0;
                sh_color = 9'd0;
                sb_q.push_back(RST_PIX);
            end else begin
                if (t % FR == 0) begin
                    sh_mode  = mode;
                    sh_color = color;
                end
                sb_q.push_back(expect_pixel(t, sh_mode, sh_color));
                t++;
            end
        end
    end

    // Monitor: outputs are sampled away from the active edge; while reset is high they must hold reset values.
    initial begin
        pix_t exp_p, got_p;
        forever begin
            @(negedge clk_pixel);
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty at %0t", $time);
            end else begin
                exp_p = sb_q.pop_front();
                if (reset) exp_p = RST_PIX;
                got_p = {red, green, blue, hsync, vsync, blank, frame, x, y};
                if (got_p !== exp_p) begin
                    errors++;
                    if (errors <= 20)
                        $display("FAIL pixel at %0t: got rgb=%0d,%0d,%0d hs=%0b vs=%0b blank=%0b frame=%0b x=%0d y=%0d, expected rgb=%0d,%0d,%0d hs=%0b vs=%0b blank=%0b frame=%0b x=%0d y=%0d",
                                 $time, got_p[34:32], got_p[31:29], got_p[28:26], got_p[25], got_p[24], got_p[23], got_p[22], got_p[21:11], got_p[10:0],
                                 exp_p[34:32], exp_p[31:29], exp_p[28:26], exp_p[25], exp_p[24], exp_p[23], exp_p[22], exp_p[21:11], exp_p[10:0]);
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk_pixel);
        #2;
    endtask

    initial begin
        color = 9'($urandom);
        cycles(4);
        reset = 1'b0;
        cycles(20 * H);
        mode = 2'd2;
        cycles(FR);
        mode = 2'd1;
        cycles(FR);
        mode = 2'd3;
        cycles(FR);
        repeat (3) begin
            cycles($urandom_range(1, FR));
            mode  = 2'($urandom_range(0, 3));
            color = 9'($urandom);
        end
        cycles(30 * H);
        reset = 1'b1;
        cycles(3);
        reset = 1'b0;
        mode  = 2'd1;
        cycles(FR + H);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
